// File: rtl/uart_oversampled_receiver_if.sv
// Receive-side word interface of uart_oversampled_receiver: received word, status flags and the consumer handshake.
// A word transfers on any rising clock edge where rxValid && rxReady. rxValid, rxData and the flags stay stable until that transfer.
interface uart_oversampled_receiver_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] rxData;
  logic                  rxValid;
  logic                  rxReady;
  logic                  parityError;
  logic                  framingError;
  logic                  overrunError;

  modport master (
    output rxData, rxValid, parityError, framingError, overrunError,
    input  rxReady
  );

  modport slave (
    input  rxData, rxValid, parityError, framingError, overrunError,
    output rxReady
  );
endinterface

// File: rtl/uart_oversampled_receiver.sv
// Oversampled UART receiver: synchronised rx, per-frame latched format, parity/framing/overrun status.
// Define UART_RX_MAJORITY_VOTE_EN to decide each bit by a 2-of-3 vote around the mid-bit tick.
module uart_oversampled_receiver #(
  parameter int DATA_WIDTH   = 8,
  parameter int OVERSAMPLING = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  input  logic [15:0] baudDivisor,
  input  logic [3:0]  dataBits,
  input  logic        parityEnable,
  input  logic        parityType,
  input  logic [1:0]  stopBits,
  output logic [2:0]  fsm_state,
  uart_oversampled_receiver_if.master word
);

  localparam int CW = $clog2(OVERSAMPLING);
  localparam logic [CW-1:0] OS_LAST = CW'(OVERSAMPLING - 1);
  localparam logic [CW-1:0] MID     = CW'(OVERSAMPLING / 2);
`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam logic [CW-1:0] MID_M1  = CW'(OVERSAMPLING / 2 - 1);
  localparam logic [CW-1:0] DECIDE  = CW'(OVERSAMPLING / 2 + 1);
`else
  localparam logic [CW-1:0] DECIDE  = MID;
`endif
  localparam logic [7:0] DW = 8'(DATA_WIDTH);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state;
  logic                  rx_meta, rx_sync, rx_prev;
  logic [15:0]           div_cnt;
  logic [CW-1:0]         os_cnt;
  logic [3:0]            nbits_q, bit_cnt;
  logic                  par_en_q, par_type_q, two_stop_q, stop_cnt;
  logic [DATA_WIDTH-1:0] shift_q;
  logic                  par_acc, par_err, frame_err;
`ifdef UART_RX_MAJORITY_VOTE_EN
  logic [1:0]            vote_q;
`endif

  logic [15:0]           div_last;
  logic                  tick, decide, bit_val, done, done_ferr;
  logic [DATA_WIDTH-1:0] aligned;

  always_comb begin
    div_last = (baudDivisor == 16'd0) ? 16'd0 : baudDivisor - 16'd1;
    tick     = (state != IDLE) && (div_cnt >= div_last);
    decide   = tick && (os_cnt == DECIDE);
`ifdef UART_RX_MAJORITY_VOTE_EN
    bit_val  = (vote_q[0] & vote_q[1]) | (vote_q[0] & rx_sync) | (vote_q[1] & rx_sync);
`else
    bit_val  = rx_sync;
`endif
    done      = decide && (state == STOP) && (stop_cnt == two_stop_q);
    done_ferr = frame_err | ~bit_val;
    // Data shifts in from the top, so short frames sit high and are moved down here.
    aligned   = shift_q >> (DW - {4'd0, nbits_q});
  end

  assign fsm_state = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state              <= IDLE;
      rx_meta            <= 1'b1;
      rx_sync            <= 1'b1;
      rx_prev            <= 1'b1;
      div_cnt            <= '0;
      os_cnt             <= '0;
      nbits_q            <= 4'd8;
      bit_cnt            <= '0;
      par_en_q           <= 1'b0;
      par_type_q         <= 1'b0;
      two_stop_q         <= 1'b0;
      stop_cnt           <= 1'b0;
      shift_q            <= '0;
      par_acc            <= 1'b0;
      par_err            <= 1'b0;
      frame_err          <= 1'b0;
`ifdef UART_RX_MAJORITY_VOTE_EN
      vote_q             <= 2'b11;
`endif
      word.rxData        <= '0;
      word.rxValid       <= 1'b0;
      word.parityError   <= 1'b0;
      word.framingError  <= 1'b0;
      word.overrunError  <= 1'b0;
    end else begin
      rx_meta           <= rx;
      rx_sync           <= rx_meta;
      rx_prev           <= rx_sync;
      word.overrunError <= 1'b0;

      if (state == IDLE) begin
        div_cnt <= '0;
        os_cnt  <= '0;
        if (rx_prev && !rx_sync) begin
          state      <= START;
          nbits_q    <= (dataBits >= 4'd5 && dataBits <= 4'd8) ? dataBits : 4'd8;
          par_en_q   <= parityEnable;
          par_type_q <= parityType;
          two_stop_q <= (stopBits == 2'd2);
          bit_cnt    <= '0;
          stop_cnt   <= 1'b0;
          shift_q    <= '0;
          par_acc    <= 1'b0;
          par_err    <= 1'b0;
          frame_err  <= 1'b0;
        end
      end else begin
        if (tick) begin
          div_cnt <= '0;
          os_cnt  <= (os_cnt == OS_LAST) ? '0 : os_cnt + 1'b1;
        end else begin
          div_cnt <= div_cnt + 16'd1;
        end
`ifdef UART_RX_MAJORITY_VOTE_EN
        if (tick && os_cnt == MID_M1) vote_q[0] <= rx_sync;
        if (tick && os_cnt == MID)    vote_q[1] <= rx_sync;
`endif
        if (decide) begin
          case (state)
            START: state <= bit_val ? IDLE : DATA;
            DATA: begin
              shift_q <= {bit_val, shift_q[DATA_WIDTH-1:1]};
              par_acc <= par_acc ^ bit_val;
              if (bit_cnt == nbits_q - 4'd1) state <= par_en_q ? PARITY : STOP;
              else                           bit_cnt <= bit_cnt + 4'd1;
            end
            PARITY: begin
              par_err <= ((par_acc ^ bit_val) != par_type_q);
              state   <= STOP;
            end
            STOP: begin
              if (!bit_val) frame_err <= 1'b1;
              if (stop_cnt == two_stop_q) state <= IDLE;
              else                        stop_cnt <= 1'b1;
            end
            default: state <= IDLE;
          endcase
        end
      end

      // A completed frame loads only if the slot is free or being drained this cycle.
      if (done && (!word.rxValid || word.rxReady)) begin
        word.rxData       <= aligned;
        word.parityError  <= par_err;
        word.framingError <= done_ferr;
        word.rxValid      <= 1'b1;
      end else if (done) begin
        word.overrunError <= 1'b1;
      end else if (word.rxValid && word.rxReady) begin
        word.rxValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_oversampled_receiver.sv
// Directed bench for uart_oversampled_receiver: driver tasks push expected words, a negedge monitor pops and compares.
module tb_uart_oversampled_receiver;
  localparam int DW      = 8;
  localparam int W       = DW + 2;
  localparam int DIV     = 4;
  localparam int BIT_CYC = 16 * DIV;
`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam logic GLITCH = 1'b1;
`else
  localparam logic GLITCH = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx = 1'b1;
  logic [15:0] baudDivisor;
  logic [3:0]  dataBits;
  logic        parityEnable;
  logic        parityType;
  logic [1:0]  stopBits;
  logic [2:0]  fsm_state;

  uart_oversampled_receiver_if #(.DATA_WIDTH(DW)) bus ();

  uart_oversampled_receiver #(.DATA_WIDTH(DW), .OVERSAMPLING(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx),
    .baudDivisor  (baudDivisor),
    .dataBits     (dataBits),
    .parityEnable (parityEnable),
    .parityType   (parityType),
    .stopBits     (stopBits),
    .fsm_state    (fsm_state),
    .word         (bus.master)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_w;
  int checks   = 0;
  int errors   = 0;
  int accepted = 0;
  int oe_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  // monitor
  always @(negedge clk) begin
    if (bus.overrunError) oe_count++;
    if (bus.rxValid && bus.rxReady) begin
      accepted++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got 0x%0h required none",
                 {bus.framingError, bus.parityError, bus.rxData});
      end else begin
        exp_w = exp_q.pop_front();
        check("word_fe_pe_data", {22'd0, bus.framingError, bus.parityError, bus.rxData}, {22'd0, exp_w});
      end
    end
  end

  // driver tasks
  task automatic drive_bit(input logic b, input logic glitch);
    for (int c = 0; c < BIT_CYC; c++) begin
      rx = (glitch && c >= 35 && c < 39) ? ~b : b;
      @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input int nbits, input logic par_en,
                            input logic par_bit, input logic [1:0] stops, input int nstop,
                            input logic glitch);
    drive_bit(1'b0, glitch);
    for (int i = 0; i < nbits; i++) drive_bit(d[i], glitch);
    if (par_en) drive_bit(par_bit, glitch);
    for (int i = 0; i < nstop; i++) drive_bit(stops[i], glitch);
    rx = 1'b1;
  endtask

  task automatic set_ready(input logic r);
    @(posedge clk);
    #1 bus.rxReady = r;
    @(negedge clk);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 4 * BIT_CYC && exp_q.size() != 0; i++) @(negedge clk);
    check(name, exp_q.size(), 0);
  endtask

  task automatic set_8e1();
    dataBits     = 4'd8;
    parityEnable = 1'b1;
    parityType   = 1'b0;
    stopBits     = 2'd1;
  endtask

  int acc0;

  initial begin
    baudDivisor = 16'(DIV);
    set_8e1();
    bus.rxReady = 1'b1;
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", bus.rxValid, 0);
    check("rst_data", bus.rxData, 0);
    check("rst_parity", bus.parityError, 0);
    check("rst_framing", bus.framingError, 0);
    check("rst_overrun", bus.overrunError, 0);
    check("rst_state", fsm_state, 0);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    // 8E1, good parity
    exp_q.push_back({1'b0, 1'b0, 8'hA5});
    send_frame(8'hA5, 8, 1'b1, 1'b0, 2'b11, 1, 1'b0);
    wait_drain("drain_a5");

    // 8E1, wrong parity
    exp_q.push_back({1'b0, 1'b1, 8'h3C});
    send_frame(8'h3C, 8, 1'b1, 1'b1, 2'b11, 1, 1'b0);
    wait_drain("drain_3c");

    // 5N2, second stop bit low
    dataBits = 4'd5; parityEnable = 1'b0; stopBits = 2'd2;
    exp_q.push_back({1'b1, 1'b0, 8'h15});
    send_frame(8'h15, 5, 1'b0, 1'b0, 2'b01, 2, 1'b0);
    wait_drain("drain_15");
    repeat (BIT_CYC) @(negedge clk);

    // overrun: consumer stalled across two back-to-back frames
    set_8e1();
    set_ready(1'b0);
    exp_q.push_back({1'b0, 1'b0, 8'h11});
    send_frame(8'h11, 8, 1'b1, 1'b0, 2'b11, 1, 1'b0);
    send_frame(8'h22, 8, 1'b1, 1'b0, 2'b11, 1, 1'b0);
    repeat (BIT_CYC) @(negedge clk);
    check("overrun_pulses", oe_count, 1);
    check("hold_valid", bus.rxValid, 1);
    check("hold_data", bus.rxData, 8'h11);
    set_ready(1'b1);
    wait_drain("drain_11");
    repeat (4) @(negedge clk);
    check("valid_falls", bus.rxValid, 0);

    // false start
    acc0 = accepted;
    rx = 1'b0;
    repeat (10) @(negedge clk);
    check("false_start_entered", fsm_state, 1);
    repeat (10) @(negedge clk);
    rx = 1'b1;
    repeat (3 * BIT_CYC) @(negedge clk);
    check("false_start_idle", fsm_state, 0);
    check("false_start_no_word", accepted, acc0);
    check("false_start_valid", bus.rxValid, 0);

    // reset during DATA of 0x5A (start, bits 0..2 = 0,1,0)
    acc0 = accepted;
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b0, 1'b0);
    check("mid_frame_data_state", fsm_state, 2);
    reset = 1'b0;
    @(negedge clk);
    check("abort_state", fsm_state, 0);
    check("abort_valid", bus.rxValid, 0);
    rx = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    exp_q.push_back({1'b0, 1'b0, 8'h81});
    send_frame(8'h81, 8, 1'b1, 1'b0, 2'b11, 1, GLITCH);
    wait_drain("drain_81");
    repeat (BIT_CYC) @(negedge clk);
    check("after_reset_words", accepted - acc0, 1);
    check("overrun_total", oe_count, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_oversampled_receiver.md
UART_OVERSAMPLED_RECEIVER -- requirements
Module: uart_oversampled_receiver

Interface
REQ-001 Parameter DATA_WIDTH, default 8: maximum data bits per frame and width of rxData.
REQ-002 Parameter OVERSAMPLING, default 16, legal 16 or 13: oversample ticks per bit.
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 rx  input  1  serial line, idle high, asynchronous to clk.
REQ-006 baudDivisor  input  16  clk cycles per oversample tick; 0 is treated as 1.
REQ-007 dataBits  input  4  data bits per frame, legal 5..8; other values are treated as 8.
REQ-008 parityEnable  input  1  parity bit present when 1.
REQ-009 parityType  input  1  0 even, 1 odd.
REQ-010 stopBits  input  2  1 or 2 stop bits; other values are treated as 1.
REQ-011 rxData  output  DATA_WIDTH  received word, LSB first on line, unused upper bits zero.
REQ-012 rxValid  output  1  rxData/flags hold a completed frame.
REQ-013 rxReady  input  1  consumer accepts the word when rxValid&&rxReady.
REQ-014 parityError, framingError  output  1 each  status for the word in rxData, valid with rxValid.
REQ-015 overrunError  output  1  one-cycle pulse, frame completed while rxValid was high.

Function
REQ-016 rx SHALL pass through a 2-flop synchroniser; all decisions use the synchronised value.
REQ-017 A tick counter SHALL pulse one cycle every baudDivisor clk cycles while not IDLE, and restart at 0 on leaving IDLE.
REQ-018 States SHALL be IDLE, START, DATA, PARITY, STOP; no other reachable state.
REQ-019 IDLE->START on synchronised high-to-low transition; dataBits/parityEnable/parityType/stopBits SHALL be latched on that cycle and held for the frame.
REQ-020 Each bit SHALL span OVERSAMPLING ticks and be sampled at tick index OVERSAMPLING/2 (8 of 16, 6 of 13).
REQ-021 START: sample 1 -> IDLE (false start, no outputs change); sample 0 -> DATA.
REQ-022 DATA: shift in exactly the latched dataBits count, LSB first; then PARITY if enabled, else STOP.
REQ-023 PARITY: parityError = XOR(data bits, parity bit) != parityType.
REQ-024 STOP: every stop-bit sample SHALL be 1, else framingError=1; frame completes at the mid-sample of the last stop bit and state returns to IDLE the next cycle, permitting back-to-back frames.
REQ-025 On completion with rxValid=0 or rxReady=1 in the same cycle: rxData, flags load and rxValid=1 next cycle.
REQ-026 On completion with rxValid=1 and rxReady=0: frame is discarded, held word kept, overrunError pulses one cycle.
REQ-027 rxValid SHALL fall the cycle after rxValid&&rxReady unless a new frame loads in that same cycle.
REQ-028 rxData, rxValid, flags SHALL remain stable while rxValid=1 and rxReady=0.

Reset
REQ-029 Reset asserted SHALL immediately force IDLE, counters 0, synchroniser to 1, rxData=0, rxValid=0, parityError=0, framingError=0, overrunError=0.
REQ-030 Reset mid-frame SHALL abandon the frame; after deassertion the receiver waits for a new falling edge.

Configuration
REQ-031 Macro UART_RX_MAJORITY_VOTE_EN defined: each bit value is the 2-of-3 majority of samples at ticks OVERSAMPLING/2-1, OVERSAMPLING/2, OVERSAMPLING/2+1, with decision at the last of these.
REQ-032 Macro undefined: single sample at tick OVERSAMPLING/2; no vote logic compiled.

Verification
REQ-033 baudDivisor=4, OVERSAMPLING=16, 8 data bits, even parity, 1 stop bit, send 0xA5 with parity 0 -> rxData=0xA5, rxValid=1, all error flags 0.
REQ-034 Same setup, send 0x3C with parity bit 1 -> rxData=0x3C, parityError=1.
REQ-035 5 data bits, no parity, 2 stop bits, second stop bit driven 0, send 0x15 -> rxData=0x15, framingError=1.
REQ-036 rxReady held 0, send 0x11 then 0x22 back-to-back -> rxData stays 0x11, overrunError pulses once at second frame end.
REQ-037 Drive rx low for 20 clk cycles only -> state returns to IDLE, rxValid stays 0.
REQ-038 Assert reset during DATA of 0x5A, release, then send 0x81 -> only 0x81 delivered; with UART_RX_MAJORITY_VOTE_EN, a one-tick glitch at each mid-sample of 0x81 still yields 0x81.
